bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: NREQ, default 3, number of bus requesters (2..4).
REQ-002 Parameter: TIMEOUT, default 255, maximum grant cycles before forced release (1..65535).
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port req  input  NREQ  per-requester bus request, level, held high for the whole transaction.
REQ-006 The block SHALL have port req_addr_en  input  NREQ  per-requester memory address-latch strobe.
REQ-007 The block SHALL have port req_in_en  input  NREQ  per-requester memory write strobe.
REQ-008 The block SHALL have port req_out_en  input  NREQ  per-requester memory read-drive strobe.
REQ-009 The block SHALL have port grant  output  NREQ  one-hot grant, registered.
REQ-010 The block SHALL have port owner  output  2  index of current grantee; valid only while busy.
REQ-011 The block SHALL have port busy  output  1  high while in GRANT.
REQ-012 The block SHALL have port mem_addr_en, mem_in_en, mem_out_en  output  1 each  gated strobes to the memory.
REQ-013 The block SHALL have port timeout  output  1  one-cycle pulse on forced release.

Function
REQ-014 FSM states SHALL be IDLE, GRANT and TURN.
REQ-015 IDLE: on any req bit high, the FSM SHALL enter GRANT next edge; grant latency is exactly 1 cycle.
REQ-016 Winner selection SHALL be round-robin: first requesting index scanning upward, with wrap, from last_owner+1.
REQ-017 last_owner SHALL update on entry to GRANT.
REQ-018 GRANT: grant SHALL stay constant while req[owner] is high; other requests are ignored (no preemption).
REQ-019 GRANT: req[owner] low SHALL cause entry to TURN next edge.
REQ-020 TURN SHALL last exactly one cycle with grant zero and all mem strobes low (bus turnaround), then go to IDLE.
REQ-021 A new grant SHALL therefore appear no earlier than 3 cycles after the previous owner's req falls.
REQ-022 mem_* strobes SHALL be combinational: the req_* bit of owner ANDed with busy; non-owner strobes SHALL have no effect.
REQ-023 req and a strobe from the same requester in the cycle grant rises SHALL be allowed; the strobe passes once grant is high.
REQ-024 All req bits falling in the same cycle SHALL behave as a normal release.
REQ-025 grant SHALL never have more than one bit set.

Reset
REQ-026 While rst is low, state SHALL be IDLE, grant 0, owner 0, busy 0, timeout 0 and last_owner NREQ-1, so requester 0 wins first.
REQ-027 Reset asserted mid-GRANT SHALL drop grant and mem strobes immediately (asynchronously).

Configuration
REQ-028 Macro BUS_ARBITER_TIMEOUT_EN defined SHALL enable a 16-bit hold counter that clears on GRANT entry and increments each GRANT cycle.
REQ-029 With the macro, when the counter reaches TIMEOUT, the FSM SHALL go to TURN and pulse timeout in that same edge.
REQ-030 With the macro, the offending requester SHALL be masked from arbitration until its req goes low.
REQ-031 Macro undefined: no counter and no mask SHALL be built, timeout SHALL be tied 0, and a grant SHALL be held indefinitely.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (IDLE=0, GRANT=1, TURN=2) and the default TIMEOUT.
REQ-033 Round-robin selection SHALL be one combinational sub-module rr_pick (inputs: request vector and last_owner; outputs: winner index and valid).
REQ-034 Instantiation in tiny16 SHALL place it between the controller and the memory strobes, with the controller as requester 0.

Verification
REQ-035 After reset, req=3'b011 -> grant=3'b001 one cycle later and owner=0; mem strobes follow req_*[0] only.
REQ-036 req[0] drops while req[1] is held -> one TURN cycle with grant=0, then IDLE, then grant=3'b010, with grant rising 3 cycles after the fall.
REQ-037 All three requesting continuously with 2-cycle transactions -> grant order 0,1,2,0 and no bit ever starved.
REQ-038 Requester 2 pulses req_in_en while requester 0 owns -> mem_in_en stays 0.
REQ-039 BUS_ARBITER_TIMEOUT_EN with TIMEOUT=4 and req[0] stuck high -> grant lost after 4 GRANT cycles, timeout pulses once, and req[0] is not re-granted until it drops.
REQ-040 rst pulled low mid-GRANT -> grant, busy and mem strobes go 0 without a clock edge; after release, requester 0 wins first again.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared FSM encoding and defaults for the bus arbiter
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT = 255;
    localparam int HOLD_CNT_W      = 16;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rtl/bus_arbiter_rr_pick.sv - combinational round-robin winner selection
module rr_pick #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last_owner,
    output logic [1:0]      winner,
    output logic            valid
);

    int idx;

    // Scan downward so the last hit is the nearest index above last_owner.
    always_comb begin
        winner = 2'd0;
        valid  = 1'b0;
        idx    = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last_owner) + k) % NREQ;
            if (req[idx]) begin
                winner = 2'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter with turnaround cycle and gated memory strobes
// Optional hold-timeout and requester masking enabled by BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] req_addr_en,
    input  logic [NREQ-1:0] req_in_en,
    input  logic [NREQ-1:0] req_out_en,
    output logic [NREQ-1:0] grant,
    output logic [1:0]      owner,
    output logic            busy,
    output logic            mem_addr_en,
    output logic            mem_in_en,
    output logic            mem_out_en,
    output logic            timeout
);

    if (NREQ < 2 || NREQ > 4 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_params
        $error("bus_arbiter: NREQ or TIMEOUT out of range");
    end

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic [1:0]      last_owner;
    logic [NREQ-1:0] eligible;
    logic [1:0]      pick_winner;
    logic            pick_valid;
    logic            take_grant;
    logic            owner_req;
    logic            expire;
    logic [NREQ-1:0] grant_nxt;

    // grant is one-hot of owner during GRANT and zero otherwise, so it doubles as the owner mask.
    assign owner_req   = |(req & grant);
    assign busy        = (state == GRANT);
    assign mem_addr_en = |(req_addr_en & grant);
    assign mem_in_en   = |(req_in_en & grant);
    assign mem_out_en  = |(req_out_en & grant);
    assign grant_nxt   = {{(NREQ-1){1'b0}}, 1'b1} << pick_winner;

    rr_pick #(
        .NREQ(NREQ)
    ) u_rr_pick (
        .req        (eligible),
        .last_owner (last_owner),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    always_comb begin
        state_nxt  = state;
        take_grant = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt  = GRANT;
                    take_grant = 1'b1;
                end
            end
            GRANT: begin
                if (!owner_req || expire) begin
                    state_nxt = TURN;
                end
            end
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= '0;
            owner      <= 2'd0;
            last_owner <= 2'(NREQ - 1);
        end else begin
            state <= state_nxt;
            if (take_grant) begin
                grant      <= grant_nxt;
                owner      <= pick_winner;
                last_owner <= pick_winner;
            end else if (state_nxt != GRANT) begin
                grant <= '0;
            end
        end
    end

`ifdef BUS_ARBITER_TIMEOUT_EN
    logic [HOLD_CNT_W-1:0] hold_cnt;
    logic [NREQ-1:0]       mask;
    logic                  force_release;

    assign eligible      = req & ~mask;
    assign expire        = (hold_cnt == HOLD_CNT_W'(TIMEOUT - 1));
    assign force_release = busy && owner_req && expire;

    // A timed-out requester stays masked until it drops its request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
            mask     <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= force_release;
            if (take_grant) begin
                hold_cnt <= '0;
            end else if (busy) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            mask <= (mask | (force_release ? grant : '0)) & req;
        end
    end
`else
    assign eligible = req;
    assign expire   = 1'b0;
    assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter with randomized reference-model run
module tb_bus_arbiter;

    localparam int NREQ = 3;
    localparam int TMO  = 4;
`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] req = '0;
    logic [2:0] req_addr_en = '0;
    logic [2:0] req_in_en = '0;
    logic [2:0] req_out_en = '0;
    logic [2:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       mem_addr_en;
    logic       mem_in_en;
    logic       mem_out_en;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner index (-1 when nobody holds the bus), turnaround flag, etc.
    int         m_owner;
    bit         m_turn;
    int         m_last;
    int         m_cnt;
    logic [2:0] m_mask;
    bit         m_tpulse;

    bus_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_addr_en (req_addr_en),
        .req_in_en   (req_in_en),
        .req_out_en  (req_out_en),
        .grant       (grant),
        .owner       (owner),
        .busy        (busy),
        .mem_addr_en (mem_addr_en),
        .mem_in_en   (mem_in_en),
        .mem_out_en  (mem_out_en),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick_rr(input logic [2:0] cand, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (cand[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_turn   = 1'b0;
        m_last   = NREQ - 1;
        m_cnt    = 0;
        m_mask   = '0;
        m_tpulse = 1'b0;
    endtask

    task automatic model_step();
        int         nxt_owner;
        bit         nxt_turn;
        bit         tp;
        logic [2:0] set;
        int         w;
        nxt_owner = m_owner;
        nxt_turn  = 1'b0;
        tp        = 1'b0;
        set       = '0;
        if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                nxt_owner = -1;
                nxt_turn  = 1'b1;
            end else if (TO_EN && (m_cnt + 1 >= TMO)) begin
                nxt_owner    = -1;
                nxt_turn     = 1'b1;
                tp           = 1'b1;
                set[m_owner] = 1'b1;
            end else begin
                m_cnt++;
            end
        end else if (!m_turn) begin
            w = pick_rr(req & ~m_mask, m_last);
            if (w >= 0) begin
                nxt_owner = w;
                m_last    = w;
                m_cnt     = 0;
            end
        end
        m_mask   = (m_mask | set) & req;
        m_owner  = nxt_owner;
        m_turn   = nxt_turn;
        m_tpulse = tp;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0; req_addr_en = '0; req_in_en = '0; req_out_en = '0;
        cyc();
        cyc();
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = 3'b111; req_addr_en = 3'b111; req_in_en = 3'b111; req_out_en = 3'b111;
        cyc();
        cyc();
        n_checks++;
        if (grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b want 000", grant); end
        n_checks++;
        if (busy !== 1'b0 || owner !== 2'd0 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: busy=%b owner=%0d timeout=%b want 0 0 0", busy, owner, timeout);
        end
        n_checks++;
        if ({mem_addr_en, mem_in_en, mem_out_en} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 000", {mem_addr_en, mem_in_en, mem_out_en});
        end
        do_reset();
    endtask

    task automatic test_first_grant_and_handover();
        do_reset();
        req = 3'b011; req_addr_en = 3'b011; req_in_en = 3'b010;
        #1;
        n_checks++;
        if (grant !== 3'b000) begin n_fail++; $display("FAIL grant_latency: got %b before edge want 000", grant); end
        cyc();
        n_checks++;
        if (grant !== 3'b001 || owner !== 2'd0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL first_grant: grant=%b owner=%0d busy=%b want 001 0 1", grant, owner, busy);
        end
        n_checks++;
        if (mem_addr_en !== 1'b1 || mem_in_en !== 1'b0 || mem_out_en !== 1'b0) begin
            n_fail++; $display("FAIL owner_strobes: got %b%b%b want 100", mem_addr_en, mem_in_en, mem_out_en);
        end
        req = 3'b010;
        cyc();
        n_checks++;
        if (grant !== 3'b000 || busy !== 1'b0 || mem_addr_en !== 1'b0) begin
            n_fail++; $display("FAIL turn_cycle: grant=%b busy=%b addr=%b want 000 0 0", grant, busy, mem_addr_en);
        end
        cyc();
        n_checks++;
        if (grant !== 3'b000) begin n_fail++; $display("FAIL idle_after_turn: got %b want 000", grant); end
        cyc();
        n_checks++;
        if (grant !== 3'b010 || owner !== 2'd1) begin
            n_fail++; $display("FAIL handover_grant: grant=%b owner=%0d want 010 1", grant, owner);
        end
        req = '0; req_addr_en = '0; req_in_en = '0;
        cyc();
        cyc();
    endtask

    task automatic test_round_robin();
        int order[4] = '{0, 1, 2, 0};
        int o;
        do_reset();
        req = 3'b111;
        for (int t = 0; t < 4; t++) begin
            for (int w = 0; w < 10 && grant == 3'b000; w++) cyc();
            if (grant == 3'b000) cyc();
            o = (grant == 3'b010) ? 1 : (grant == 3'b100) ? 2 : 0;
            n_checks++;
            if (grant !== (3'b001 << order[t])) begin
                n_fail++; $display("FAIL rr_order[%0d]: grant=%b want %b", t, grant, 3'b001 << order[t]);
            end
            cyc();
            req[o] = 1'b0;
            cyc();
            req[o] = 1'b1;
        end
        req = '0;
        cyc();
        cyc();
    endtask

    task automatic test_non_owner_strobe();
        do_reset();
        req = 3'b101;
        cyc();
        req_in_en = 3'b100;
        #1;
        n_checks++;
        if (grant !== 3'b001 || mem_in_en !== 1'b0) begin
            n_fail++; $display("FAIL non_owner_in: grant=%b mem_in_en=%b want 001 0", grant, mem_in_en);
        end
        req_in_en = 3'b001;
        req_out_en = 3'b100;
        #1;
        n_checks++;
        if (mem_in_en !== 1'b1 || mem_out_en !== 1'b0) begin
            n_fail++; $display("FAIL owner_in: in=%b out=%b want 1 0", mem_in_en, mem_out_en);
        end
        req = '0; req_in_en = '0; req_out_en = '0;
        cyc();
        cyc();
    endtask

    task automatic test_hold_limit();
        int pulses;
        do_reset();
        req = 3'b001;
        cyc();
        pulses = 0;
        if (TO_EN) begin
            for (int i = 1; i <= TMO - 1; i++) begin
                cyc();
                n_checks++;
                if (grant !== 3'b001 || timeout !== 1'b0) begin
                    n_fail++; $display("FAIL hold_cycle[%0d]: grant=%b timeout=%b want 001 0", i, grant, timeout);
                end
            end
            cyc();
            n_checks++;
            if (grant !== 3'b000 || timeout !== 1'b1) begin
                n_fail++; $display("FAIL forced_release: grant=%b timeout=%b want 000 1", grant, timeout);
            end
            for (int i = 0; i < 8; i++) begin
                cyc();
                if (timeout === 1'b1) pulses++;
                n_checks++;
                if (grant !== 3'b000) begin
                    n_fail++; $display("FAIL masked_regrant[%0d]: grant=%b want 000", i, grant);
                end
            end
            n_checks++;
            if (pulses !== 0) begin n_fail++; $display("FAIL timeout_single: extra pulses=%0d want 0", pulses); end
            req = 3'b000;
            cyc();
            req = 3'b001;
            cyc();
            n_checks++;
            if (grant !== 3'b001) begin n_fail++; $display("FAIL unmask_regrant: grant=%b want 001", grant); end
        end else begin
            for (int i = 0; i < 40; i++) begin
                cyc();
                if (timeout === 1'b1) pulses++;
                n_checks++;
                if (grant !== 3'b001) begin
                    n_fail++; $display("FAIL hold_forever[%0d]: grant=%b want 001", i, grant);
                end
            end
            n_checks++;
            if (pulses !== 0) begin n_fail++; $display("FAIL timeout_tied: pulses=%0d want 0", pulses); end
        end
        req = '0;
        cyc();
        cyc();
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 3'b011; req_addr_en = 3'b001; req_out_en = 3'b001;
        cyc();
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (grant !== 3'b000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_grant: grant=%b busy=%b want 000 0", grant, busy);
        end
        n_checks++;
        if (mem_addr_en !== 1'b0 || mem_out_en !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_strobes: addr=%b out=%b want 0 0", mem_addr_en, mem_out_en);
        end
        #2;
        rst = 1'b1;
        cyc();
        n_checks++;
        if (grant !== 3'b001 || owner !== 2'd0) begin
            n_fail++; $display("FAIL post_reset_winner: grant=%b owner=%0d want 001 0", grant, owner);
        end
        req = '0; req_addr_en = '0; req_out_en = '0;
        cyc();
        cyc();
    endtask

    task automatic test_random();
        int         g_len[3];
        bit         g_started[3];
        bit         g_cool[3];
        logic [2:0] exp_grant;
        bit         exp_busy;
        logic [2:0] exp_mem;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            g_len[i] = 0; g_started[i] = 0; g_cool[i] = 0;
        end
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!req[i]) begin
                    if (g_cool[i]) g_cool[i] = 0;
                    else if ($urandom_range(2) == 0) begin
                        req[i] = 1'b1; g_len[i] = $urandom_range(1, 6); g_started[i] = 0;
                    end
                end else begin
                    if (m_owner == i) g_started[i] = 1;
                    if (g_started[i]) begin
                        g_len[i]--;
                        if (g_len[i] <= 0) begin req[i] = 1'b0; g_cool[i] = 1; end
                    end
                end
            end
            req_addr_en = 3'($urandom);
            req_in_en   = 3'($urandom);
            req_out_en  = 3'($urandom);
            #1;
            exp_busy  = (m_owner >= 0);
            exp_grant = exp_busy ? (3'b001 << m_owner) : 3'b000;
            exp_mem   = exp_busy ? {req_addr_en[m_owner], req_in_en[m_owner], req_out_en[m_owner]} : 3'b000;
            n_checks++;
            if (grant !== exp_grant || busy !== exp_busy) begin
                n_fail++; $display("FAIL rand_grant cyc %0d: grant=%b busy=%b want %b %b", c, grant, busy, exp_grant, exp_busy);
            end
            if (exp_busy) begin
                n_checks++;
                if (owner !== 2'(m_owner)) begin
                    n_fail++; $display("FAIL rand_owner cyc %0d: got %0d want %0d", c, owner, m_owner);
                end
            end
            n_checks++;
            if ({mem_addr_en, mem_in_en, mem_out_en} !== exp_mem || timeout !== m_tpulse) begin
                n_fail++; $display("FAIL rand_strobes cyc %0d: mem=%b timeout=%b want %b %b", c,
                                   {mem_addr_en, mem_in_en, mem_out_en}, timeout, exp_mem, m_tpulse);
            end
            model_step();
            cyc();
        end
        req = '0; req_addr_en = '0; req_in_en = '0; req_out_en = '0;
        cyc();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_grant_and_handover();
        test_round_robin();
        test_non_owner_strobe();
        test_hold_limit();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
